// File: rtl/tt_check_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
// The sweep visits 2**N vectors; the error counter needs one extra bit to hold 2**N.
package tt_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int n_vectors(input int n);
        return 2 ** n;
    endfunction

    function automatic int count_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that paces how long each input vector is held
// before the module output is sampled.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    logic [TW-1:0] r_count;

    // Countdown register: clear beats load, load beats decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TW'(SETTLE_CYCLES);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - TW'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    // Expire on the last held cycle so the next edge lands in the sample state.
    always_comb begin
        o_expire = i_en && (r_count == TW'(1'b1));
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input vector onto a minimized logic module, samples its F output
// and compares the rebuilt truth table with a latched golden minterm mask.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [n_vectors(N_INPUTS)-1:0]      golden_mask,
    output logic [N_INPUTS-1:0]                 dut_vec,
    input  logic                                dut_f,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [count_width(N_INPUTS)-1:0]    err_count,
    output logic [N_INPUTS-1:0]                 first_fail_idx,
    output logic                                fail_seen,
    output logic [n_vectors(N_INPUTS)-1:0]      captured_tt
);

    localparam int NV = n_vectors(N_INPUTS);
    localparam int CW = count_width(N_INPUTS);

    state_t            r_state;
    state_t            w_next;
    logic [NV-1:0]     r_mask;
    logic [NV-1:0]     r_captured_tt;
    logic [N_INPUTS-1:0] r_dut_vec;
    logic [N_INPUTS-1:0] r_first_fail_idx;
    logic [CW-1:0]     r_err_count;
    logic [CW-1:0]     w_err_next;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_fail_seen;
    logic              w_start_ok;
    logic              w_in_sample;
    logic              w_last;
    logic              w_mismatch;
    logic              w_timer_load;
    logic              w_timer_en;
    logic              w_expire;

    // Decode of the current vector, mismatch and timer controls.
    always_comb begin
        w_start_ok   = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_in_sample  = (r_state == ST_SAMPLE);
        w_last       = &r_dut_vec;
        w_mismatch   = (dut_f != r_mask[r_dut_vec]);
        w_err_next   = r_err_count + CW'(w_mismatch);
        w_timer_load = w_start_ok || (w_in_sample && !w_last);
        w_timer_en   = (r_state == ST_SETTLE);
    end

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (abort),
        .i_load   (w_timer_load),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) w_next = ST_SETTLE;
                    else       w_next = r_state;
                end
                ST_SETTLE: begin
                    if (w_expire) w_next = ST_SAMPLE;
                    else          w_next = ST_SETTLE;
                end
                ST_SAMPLE: begin
                    if (w_last) w_next = ST_DONE;
                    else        w_next = ST_SETTLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sweep datapath: mask latch, vector stepping and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask           <= '0;
            r_captured_tt    <= '0;
            r_dut_vec        <= '0;
            r_first_fail_idx <= '0;
            r_err_count      <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_seen      <= 1'b0;
        end else if (abort) begin
            r_captured_tt    <= '0;
            r_dut_vec        <= '0;
            r_first_fail_idx <= '0;
            r_err_count      <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_seen      <= 1'b0;
        end else if (w_start_ok) begin
            r_mask           <= golden_mask;
            r_captured_tt    <= '0;
            r_dut_vec        <= '0;
            r_first_fail_idx <= '0;
            r_err_count      <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_seen      <= 1'b0;
        end else if (w_in_sample) begin
            r_captured_tt[r_dut_vec] <= dut_f;
            r_err_count              <= w_err_next;
            if (w_mismatch && !r_fail_seen) begin
                r_fail_seen      <= 1'b1;
                r_first_fail_idx <= r_dut_vec;
            end else begin
                r_fail_seen      <= r_fail_seen;
                r_first_fail_idx <= r_first_fail_idx;
            end
            // The final vector stays on the bus once the sweep completes.
            if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_next == '0);
            end else begin
                r_dut_vec <= r_dut_vec + N_INPUTS'(1'b1);
            end
        end else begin
            r_mask <= r_mask;
        end
    end

    assign dut_vec        = r_dut_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_fail_idx = r_first_fail_idx;
    assign fail_seen      = r_fail_seen;
    assign captured_tt    = r_captured_tt;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: each accepted sweep pushes its expected outcome, and
// monitors compare when done rises. Two instances cover SETTLE_CYCLES 1 and 3.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    // Instance with SETTLE_CYCLES=1
    logic        start, abort, dut_f, busy, done, pass, fail_seen;
    logic [15:0] golden_mask, captured_tt, f_tt;
    logic [3:0]  dut_vec, first_fail_idx;
    logic [4:0]  err_count;

    // Instance with SETTLE_CYCLES=3
    logic        start3, abort3, dut_f3, busy3, done3, pass3, fail_seen3;
    logic [15:0] golden_mask3, captured_tt3, f_tt3;
    logic [3:0]  dut_vec3, first_fail_idx3;
    logic [4:0]  err_count3;

    // The "minimized module" is modelled as a truth table lookup on dut_vec.
    assign dut_f  = f_tt[dut_vec];
    assign dut_f3 = f_tt3[dut_vec3];

    tt_sweep_checker #(.N_INPUTS(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .golden_mask(golden_mask), .dut_vec(dut_vec), .dut_f(dut_f),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .fail_seen(fail_seen),
        .captured_tt(captured_tt)
    );

    tt_sweep_checker #(.N_INPUTS(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .golden_mask(golden_mask3), .dut_vec(dut_vec3), .dut_f(dut_f3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .first_fail_idx(first_fail_idx3), .fail_seen(fail_seen3),
        .captured_tt(captured_tt3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  err;
        logic [3:0]  ffi;
        logic        fs;
        logic        ps;
        int          start_edge;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // F = A'BD + BCD' + ACD + AB'C'D', evaluated per minterm from its sum of products.
    function automatic logic [15:0] ref_tt();
        logic [15:0] t;
        logic a, b, c, d;
        t = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            a = (i / 8) % 2 == 1;
            b = (i / 4) % 2 == 1;
            c = (i / 2) % 2 == 1;
            d = i % 2 == 1;
            t[i] = (!a && b && d) || (b && c && !d) || (a && c && d) || (a && !b && !c && !d);
        end
        return t;
    endfunction

    // Expected sweep outcome from the observed table and the mask.
    function automatic exp_t model(input logic [15:0] mask, input logic [15:0] tt,
                                   input int se, input int lat);
        exp_t e;
        logic [15:0] diff;
        diff = mask ^ tt;
        e.tt = tt;
        e.err = 5'd0;
        e.ffi = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                e.err = e.err + 5'd1;
                e.ffi = 4'(i);
            end
        end
        e.fs = (diff != 16'h0000);
        e.ps = (diff == 16'h0000);
        e.start_edge = se;
        e.lat = lat;
        return e;
    endfunction

    logic prev_done1 = 1'b0;
    logic prev_done3 = 1'b0;

    // Monitor for the SETTLE_CYCLES=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done1) begin
            if (q1.size() == 0) begin
                check("s1_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("s1_latency", 64'(cyc - e.start_edge), 64'(e.lat));
                check("s1_captured_tt", 64'(captured_tt), 64'(e.tt));
                check("s1_err_count", 64'(err_count), 64'(e.err));
                check("s1_first_fail_idx", 64'(first_fail_idx), 64'(e.ffi));
                check("s1_fail_seen", 64'(fail_seen), 64'(e.fs));
                check("s1_pass", 64'(pass), 64'(e.ps));
                check("s1_busy_at_done", 64'(busy), 64'd0);
            end
        end
        prev_done1 <= done;
    end

    // Monitor for the SETTLE_CYCLES=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done3 && !prev_done3) begin
            if (q3.size() == 0) begin
                check("s3_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q3.pop_front();
                check("s3_latency", 64'(cyc - e.start_edge), 64'(e.lat));
                check("s3_captured_tt", 64'(captured_tt3), 64'(e.tt));
                check("s3_err_count", 64'(err_count3), 64'(e.err));
                check("s3_first_fail_idx", 64'(first_fail_idx3), 64'(e.ffi));
                check("s3_pass", 64'(pass3), 64'(e.ps));
            end
        end
        prev_done3 <= done3;
    end

    task automatic wait_done1(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("s1_done_timeout", 64'(done), 64'd1);
    endtask

    // Called at a negedge; optionally pokes start again 5 edges into the sweep.
    task automatic run_sweep(input logic [15:0] mask, input logic [15:0] tt, input bit poke);
        golden_mask = mask;
        f_tt = tt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q1.push_back(model(mask, tt, cyc, 32));
        golden_mask = 16'($urandom);
        if (poke) begin
            repeat (4) @(negedge clk);
            golden_mask = ~mask;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done1(80);
    endtask

    initial begin
        logic [15:0] rtt;
        logic [15:0] m;
        logic [15:0] t;
        int bad;
        rtt = ref_tt();
        rst_n = 1'b1;
        start = 1'b0; abort = 1'b0; golden_mask = 16'h0000; f_tt = 16'h0000;
        start3 = 1'b0; abort3 = 1'b0; golden_mask3 = 16'h0000; f_tt3 = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({dut_vec, busy, done, pass, err_count, first_fail_idx, fail_seen, captured_tt}),
              64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(16'hC9E0, rtt, 1'b0);
        run_sweep(16'hC9E1, rtt, 1'b0);
        run_sweep(16'hC9E0, 16'hFFFF, 1'b0);

        // Abort sampled on the 10th edge after the start-accepting edge.
        golden_mask = 16'hC9E0;
        f_tt = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs",
              64'({dut_vec, busy, done, pass, err_count, first_fail_idx, fail_seen, captured_tt}),
              64'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 64'({busy, done}), 64'd0);
        run_sweep(16'hC9E0, rtt, 1'b0);

        // Start while busy is ignored; the original mask stays in use.
        run_sweep(16'h1234, rtt, 1'b1);

        // Start and abort together from DONE: abort wins.
        check("done_level_held", 64'(done), 64'd1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_same_cycle", 64'({busy, done, dut_vec}), 64'd0);
        repeat (2) @(negedge clk);
        check("start_abort_no_launch", 64'({busy, done}), 64'd0);

        for (int r = 0; r < 8; r++) begin
            m = 16'($urandom);
            case ($urandom_range(0, 3))
                0: t = 16'($urandom);
                1: t = rtt;
                2: t = m;
                default: t = m ^ (16'h0001 << $urandom_range(0, 15));
            endcase
            run_sweep(m, t, 1'b0);
        end

        // Asynchronous reset between clock edges mid-sweep.
        golden_mask = 16'hC9E0;
        f_tt = 16'h0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({dut_vec, busy, done, pass, err_count, first_fail_idx, fail_seen, captured_tt}),
              64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'({busy, done}), 64'd0);

        // SETTLE_CYCLES=3: each vector on the bus for 4 edges, done 64 edges later.
        golden_mask3 = 16'hC9E0;
        f_tt3 = rtt;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        q3.push_back(model(16'hC9E0, rtt, cyc, 64));
        golden_mask3 = 16'h0000;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (dut_vec3 !== 4'(k / 4)) bad++;
            @(negedge clk);
        end
        check("s3_vec_schedule", 64'(bad), 64'd0);
        check("s3_done_at_64", 64'(done3), 64'd1);

        repeat (2) @(negedge clk);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q3_drained", 64'(q3.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
